instr_decoder: RTL

INSTR_DECODER -- requirements
Module: instr_decoder

---
 rtl/instr_decoder_pkg.sv | 94 +++++++++
 rtl/instr_decoder_regfile.sv | 33 +++
 rtl/instr_decoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/instr_decoder_pkg.sv
// Shared encodings for the decoder and the ALU: MIPS opcodes/functs, operation IDs,
// FSM state encoding and the instruction field decode helper.
package instr_decoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [31:0] ID_NONE  = 32'd0;
    localparam logic [31:0] ID_ADD   = 32'd1;
    localparam logic [31:0] ID_SUB   = 32'd2;
    localparam logic [31:0] ID_ADDU  = 32'd3;
    localparam logic [31:0] ID_SUBU  = 32'd4;
    localparam logic [31:0] ID_ADDI  = 32'd5;
    localparam logic [31:0] ID_ADDIU = 32'd6;
    localparam logic [31:0] ID_AND   = 32'd7;
    localparam logic [31:0] ID_OR    = 32'd8;
    localparam logic [31:0] ID_ANDI  = 32'd9;
    localparam logic [31:0] ID_ORI   = 32'd10;
    localparam logic [31:0] ID_SLL   = 32'd11;
    localparam logic [31:0] ID_SRL   = 32'd12;
    localparam logic [31:0] ID_SLT   = 32'd24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_WB     = 2'd2
    } state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] id;
        logic [4:0]  dest;
        logic [4:0]  rs_addr;
        logic        shift;
        logic        use_imm;
        logic        imm_sext;
    } dec_t;

    function automatic dec_t decode_instr(input logic [31:0] w);
        dec_t d;
        d         = '0;
        d.rs_addr = w[25:21];
        d.legal   = 1'b1;
        if (w[31:26] == OP_RTYPE) begin
            d.dest = w[15:11];
            case (w[5:0])
                FN_ADD:  d.id = ID_ADD;
                FN_SUB:  d.id = ID_SUB;
                FN_ADDU: d.id = ID_ADDU;
                FN_SUBU: d.id = ID_SUBU;
                FN_AND:  d.id = ID_AND;
                FN_OR:   d.id = ID_OR;
                FN_SLT:  d.id = ID_SLT;
                FN_SLL, FN_SRL: begin
                    // shifts take their source from the rt field, amount from shamt
                    d.id      = (w[5:0] == FN_SLL) ? ID_SLL : ID_SRL;
                    d.shift   = 1'b1;
                    d.rs_addr = w[20:16];
                end
                default: d.legal = 1'b0;
            endcase
        end else begin
            d.dest    = w[20:16];
            d.use_imm = 1'b1;
            case (w[31:26])
                OP_ADDI:  begin d.id = ID_ADDI;  d.imm_sext = 1'b1; end
                OP_ADDIU: begin d.id = ID_ADDIU; d.imm_sext = 1'b1; end
                OP_SLTI:  begin d.id = ID_SLT;   d.imm_sext = 1'b1; end
                OP_ANDI:  d.id = ID_ANDI;
                OP_ORI:   d.id = ID_ORI;
                default:  d.legal = 1'b0;
            endcase
        end
        if (!d.legal) begin
            d.id = ID_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/instr_decoder_regfile.sv
// 32x32 register file: two operand read ports, one write port, one debug read port.
// Register 0 is hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra_addr,
    output logic [31:0] ra_data,
    input  logic [4:0]  rb_addr,
    output logic [31:0] rb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign ra_data  = (ra_addr  == 5'd0) ? 32'd0 : regs_q[ra_addr];
    assign rb_data  = (rb_addr  == 5'd0) ? 32'd0 : regs_q[rb_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];

endmodule

// File: rtl/instr_decoder.sv
// Three-cycle MIPS-subset decoder: captures an instruction, presents operands to an
// external ALU, and writes the ALU result back to its register file.
module instr_decoder
    import instr_decoder_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr_word,
    output logic        instr_ready,
    output logic [31:0] instr_ID,
    output logic [31:0] rs,
    output logic [31:0] rt,
    output logic [31:0] initial_pc,
    input  logic [31:0] rd,
    input  logic [31:0] pc,
    output logic        illegal,
    output logic [31:0] retired,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;
    dec_t        dec;
    logic        wr_en;
    logic [31:0] ra_data, rb_data;
    logic [31:0] imm_ext;

    assign dec = decode_instr(instr_q);

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr_word;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d   = ST_WB;
                illegal_d = !dec.legal;
            end
            ST_WB: begin
                state_d = ST_IDLE;
                pc_d    = pc;
                if (dec.legal) begin
                    retired_d = retired_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign wr_en   = (state_q == ST_WB) && dec.legal;
    assign imm_ext = dec.imm_sext ? {{16{instr_q[15]}}, instr_q[15:0]} : {16'd0, instr_q[15:0]};

    regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (dec.rs_addr),
        .ra_data  (ra_data),
        .rb_addr  (instr_q[20:16]),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (wr_en),
        .wr_addr  (dec.dest),
        .wr_data  (rd)
    );

    assign instr_ready = (state_q == ST_IDLE);
    assign instr_ID    = (state_q == ST_IDLE) ? ID_NONE : dec.id;
    assign rs          = ra_data;
    assign rt          = dec.shift   ? {27'd0, instr_q[10:6]} :
                         dec.use_imm ? imm_ext : rb_data;
    assign initial_pc  = pc_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule
